// File: rtl/prog_uart_tx.sv
// prog_uart_tx -- UART transmitter for the return channel of the boot-programming link.
//
// Sends status/echo bytes back to the host. The frame is 8N1, LSB first, with an idle-high
// line. The baud rate is set at run time in clocks per bit. A small byte FIFO decouples the
// producer from the bit-serial shifter, and every byte passes through that FIFO.
//
// Optional feature: define PROG_UART_TX_PARITY_EN to add an even-parity bit after data
// bit 7. This gives an 8E1 frame.
//
// Ports
//   clk_i           system clock
//   rst_ni          asynchronous active-low reset
//   clks_per_bit_i  clocks per bit, latched at frame start (0 is treated as 1)
//   tx_valid_i      producer has a byte
//   tx_byte_i       byte to send
//   tx_ready_o      FIFO not full; a transfer happens on valid & ready
//   tx_serial_o     registered UART TX line
//   tx_busy_o       frame in progress or FIFO non-empty
//   tx_done_o       1-cycle pulse after a frame's stop bit completes
//   fifo_level_o    bytes queued in the FIFO (the shifter is not counted)
module prog_uart_tx #(
    parameter int FIFO_DEPTH = 4,
    parameter int CPB_W      = 15
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic [CPB_W-1:0]              clks_per_bit_i,
    input  logic                          tx_valid_i,
    input  logic [7:0]                    tx_byte_i,
    output logic                          tx_ready_o,
    output logic                          tx_serial_o,
    output logic                          tx_busy_o,
    output logic                          tx_done_o,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level_o
);

    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam int LVL_W = AW + 1;
    localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef PROG_UART_TX_PARITY_EN
        S_PAR,
`endif
        S_STOP
    } state_t;

    // ---------------- FIFO ----------------
    logic [7:0]       r_mem [FIFO_DEPTH];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [LVL_W-1:0] r_level;

    logic             w_full;
    logic             w_empty;
    logic             w_push;
    logic             w_pop;
    logic [7:0]       w_head;

    // A push is gated on !full only. A pop in the same cycle does not free a slot for it.
    assign w_full  = (r_level == FULL_LVL);
    assign w_empty = (r_level == '0);
    assign w_push  = tx_valid_i && !w_full;
    assign w_head  = r_mem[r_rptr];

    always_ff @(posedge clk_i) begin
        if (w_push) r_mem[r_wptr] <= tx_byte_i;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_level <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + AW'(1);
            if (w_pop)  r_rptr <= r_rptr + AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + LVL_W'(1);
                2'b01:   r_level <= r_level - LVL_W'(1);
                default: r_level <= r_level;
            endcase
        end
    end

    // ---------------- Shifter FSM ----------------
    state_t           r_state;
    logic [CPB_W-1:0] r_cpb;
    logic [CPB_W-1:0] r_cnt;
    logic [2:0]       r_idx;
    logic [7:0]       r_shift;
    logic             r_tx;
    logic             r_done;

    logic             w_bit_end;
    logic [CPB_W-1:0] w_cpb_in;

    assign w_bit_end = (r_cnt == r_cpb - CPB_W'(1));
    assign w_cpb_in  = (clks_per_bit_i == '0) ? CPB_W'(1) : clks_per_bit_i;

    // Pop on leaving IDLE, or at the end of STOP so back-to-back frames have no gap.
    assign w_pop = !w_empty &&
                   ((r_state == S_IDLE) || ((r_state == S_STOP) && w_bit_end));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= S_IDLE;
            r_cpb   <= CPB_W'(1);
            r_cnt   <= '0;
            r_idx   <= '0;
            r_shift <= '0;
            r_tx    <= 1'b1;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_tx <= 1'b1;
                    if (w_pop) begin
                        r_shift <= w_head;
                        r_cpb   <= w_cpb_in;
                        r_cnt   <= '0;
                        r_tx    <= 1'b0;
                        r_state <= S_START;
                    end
                end
                S_START: begin
                    if (w_bit_end) begin
                        r_cnt   <= '0;
                        r_idx   <= '0;
                        r_tx    <= r_shift[0];
                        r_state <= S_DATA;
                    end else begin
                        r_cnt <= r_cnt + CPB_W'(1);
                    end
                end
                S_DATA: begin
                    if (w_bit_end) begin
                        r_cnt <= '0;
                        if (r_idx == 3'd7) begin
`ifdef PROG_UART_TX_PARITY_EN
                            r_tx    <= ^r_shift;
                            r_state <= S_PAR;
`else
                            r_tx    <= 1'b1;
                            r_state <= S_STOP;
`endif
                        end else begin
                            r_idx <= r_idx + 3'd1;
                            r_tx  <= r_shift[r_idx + 3'd1];
                        end
                    end else begin
                        r_cnt <= r_cnt + CPB_W'(1);
                    end
                end
`ifdef PROG_UART_TX_PARITY_EN
                S_PAR: begin
                    if (w_bit_end) begin
                        r_cnt   <= '0;
                        r_tx    <= 1'b1;
                        r_state <= S_STOP;
                    end else begin
                        r_cnt <= r_cnt + CPB_W'(1);
                    end
                end
`endif
                S_STOP: begin
                    if (w_bit_end) begin
                        r_done <= 1'b1;
                        r_cnt  <= '0;
                        if (w_pop) begin
                            // The next byte goes straight into its start bit.
                            r_shift <= w_head;
                            r_cpb   <= w_cpb_in;
                            r_tx    <= 1'b0;
                            r_state <= S_START;
                        end else begin
                            r_tx    <= 1'b1;
                            r_state <= S_IDLE;
                        end
                    end else begin
                        r_cnt <= r_cnt + CPB_W'(1);
                    end
                end
                default: begin
                    r_tx    <= 1'b1;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign tx_serial_o  = r_tx;
    assign tx_done_o    = r_done;
    assign tx_ready_o   = !w_full;
    assign fifo_level_o = r_level;
    assign tx_busy_o    = (r_state != S_IDLE) || !w_empty;

endmodule
